// File: rtl/sram_arbiter_ctrl.sv
// Two-port round-robin front end for a single-port synchronous SRAM.
// It optionally sweeps the array with INIT_VALUE after reset and returns read data tagged to the requesting port.
module sram_arbiter_ctrl #(
  parameter int            AW         = 7,
  parameter int            DW         = 16,
  parameter int            DEPTH      = 128,
  parameter int            INIT_EN    = 1,
  parameter logic [DW-1:0] INIT_VALUE = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          init_done
);

  // Handshake: a port raises req and keeps we/addr/wdata steady; the access is taken on the
  // rising edge where req && gnt. gnt is combinational, at most one port at a time, never in INIT.

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   init_cnt;
  logic            rr_ptr;
  logic            accept;
  logic            acc_port;
  logic            acc_we;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;
  logic            rd1_valid;
  logic            rd1_port;
  logic            rd2_valid;
  logic            rd2_port;

  always_comb begin
    state_next = state;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    if (state == ST_INIT) begin
      if (init_cnt == LAST_ADDR) state_next = ST_RUN;
    end else if (init_done) begin
      if (p0_req && (!p1_req || !rr_ptr)) p0_gnt = 1'b1;
      else if (p1_req)                    p1_gnt = 1'b1;
    end
    accept    = p0_gnt | p1_gnt;
    acc_port  = p1_gnt;
    acc_we    = p1_gnt ? p1_we    : p0_we;
    acc_addr  = p1_gnt ? p1_addr  : p0_addr;
    acc_wdata = p1_gnt ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= init_done | (state == ST_RUN) |
                   ((state == ST_INIT) && (init_cnt == LAST_ADDR));
    end
  end

  // Macro command register: init sweep, an accepted request, or idle with addr/din held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cen  <= 1'b1;
      mem_wen  <= 1'b1;
      mem_addr <= '0;
      mem_din  <= '0;
      init_cnt <= '0;
      rr_ptr   <= 1'b0;
    end else if (state == ST_INIT) begin
      mem_cen  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= init_cnt;
      mem_din  <= INIT_VALUE;
      init_cnt <= init_cnt + 1'b1;
    end else if (accept) begin
      mem_cen  <= 1'b0;
      mem_wen  <= ~acc_we;
      mem_addr <= acc_addr;
      mem_din  <= acc_wdata;
      rr_ptr   <= ~acc_port;
    end else begin
      mem_cen  <= 1'b1;
      mem_wen  <= 1'b1;
    end
  end

  // Owner/valid pipeline: stage 1 covers the SRAM sampling edge, stage 2 the edge where dout is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_valid <= 1'b0;
      rd1_port  <= 1'b0;
      rd2_valid <= 1'b0;
      rd2_port  <= 1'b0;
    end else begin
      rd1_valid <= accept & ~acc_we;
      rd1_port  <= acc_port;
      rd2_valid <= rd1_valid;
      rd2_port  <= rd1_port;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= rd2_valid & ~rd2_port;
      p1_rvalid <= rd2_valid & rd2_port;
      if (rd2_valid && !rd2_port) p0_rdata <= mem_dout;
      if (rd2_valid &&  rd2_port) p1_rdata <= mem_dout;
    end
  end

endmodule

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
Two-port arbitration controller in front of the single-port 128x16 synchronous SRAM macro. The macro has active-low cen and active-low wen.
- After reset, optionally sweeps the whole array with an init value.
- Then grants requests from two requesters round-robin, one SRAM access per cycle, and returns read data tagged to the requesting port.
- Sits between the datapath clients and the memory instance; it is the only block driving the macro's cen/wen/addr/data_in.

Parameters:
AW, 7, address width
DW, 16, data width
DEPTH, 128, words in SRAM (= 2**AW)
INIT_EN, 1, 1 = run init sweep after reset; 0 = go straight to RUN
INIT_VALUE, 16'h0000, word written to every location during init

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request
p0_we  in  1  port 0: 1 = write, 0 = read
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_gnt  out  1  port 0 grant (combinational, this cycle)
p0_rvalid  out  1  port 0 read data valid (registered, one-cycle pulse)
p0_rdata  out  DW  port 0 read data
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1
mem_cen  out  1  SRAM chip enable, active low
mem_wen  out  1  SRAM write enable, active low (0 = write, 1 = read)
mem_addr  out  AW  SRAM address
mem_din  out  DW  SRAM write data
mem_dout  in  DW  SRAM read data, valid after the sampling edge
init_done  out  1  high once init complete (or immediately when INIT_EN=0)

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n. Single clock domain.
- Reset values:
  - mem_cen=1, mem_wen=1, mem_addr=0, mem_din=0.
  - All gnt=0, all rvalid=0, all rdata=0, init_done=0.
  - rr_ptr=port0, init counter=0.
  - state=INIT if INIT_EN else RUN. With INIT_EN=0, init_done=1 in the first cycle after reset release.
- States: INIT, RUN.
- INIT:
  - Each cycle registers mem_cen=0, mem_wen=0, mem_addr=cnt, mem_din=INIT_VALUE, then cnt++.
  - Exactly DEPTH write cycles cover addresses 0..DEPTH-1.
  - After the edge that issues addr DEPTH-1: state=RUN and init_done=1.
  - Both gnt held 0 throughout INIT; requests wait.
- RUN arbitration (combinational):
  - If only one req is high, that port gets gnt.
  - If both are high, the port named by rr_ptr gets gnt.
  - Exactly one gnt or none, never both.
  - A request is accepted on the rising edge where req&gnt=1. Requester holds req/we/addr/wdata stable until that edge.
- On the accept edge:
  - Register mem_cen=0, mem_wen=~we, mem_addr=addr, mem_din=wdata (mem_din is don't-care on reads, but is still loaded).
  - rr_ptr := other port.
  - SRAM samples at the following edge.
- Cycle with no accept: mem_cen=1, mem_wen=1; mem_addr and mem_din hold their values. rr_ptr unchanged.
- Throughput: one access per cycle, back-to-back allowed, including a single requester streaming continuously.
- Read return:
  - A 2-stage owner/valid pipeline tags each read with its port.
  - Accept at edge E0, SRAM samples at E1, controller captures mem_dout into pX_rdata at E2. pX_rvalid is high for the one cycle following E2.
  - Read latency = 2 cycles from accept. The other port's rvalid stays 0.
  - rdata holds its value until the next read return to that port.
- Writes produce no response beyond gnt.
- Read-after-write to the same address, accepted on consecutive edges: the read returns the new data.
- Reset asserted mid-operation: everything returns to reset values immediately. In-flight reads are dropped (no rvalid). INIT restarts from address 0.
- Expected size: roughly 150-250 lines.

Test Plan:
1. Init sweep: INIT_EN=1, release rst_n -> 128 consecutive cycles with mem_cen=0, mem_wen=0, mem_addr 0..127, mem_din=0. init_done rises after the addr-127 edge. p0_req held high throughout INIT gets no gnt until init_done=1.
2. Write/read, single port: p0 writes addr 5 data 16'hA5A5, next cycle p0 reads addr 5 -> p0_rvalid pulses 2 cycles after the read accept with p0_rdata=16'hA5A5; p1_rvalid stays 0.
3. Contention: both ports hold read requests (p0 addr 10, p1 addr 20) for 6 cycles after init -> gnt order p0,p1,p0,p1,p0,p1; mem_cen=0 every cycle; rvalid alternates ports with the correct data each.
4. Streaming: p1 alone reads addrs 0..3 on consecutive cycles after init -> gnt each cycle; p1_rvalid high 4 consecutive cycles, rdata=INIT_VALUE.
5. Reset mid-read: p0 read accepted, rst_n low before the return edge -> p0_rvalid never asserts, outputs at reset values, INIT restarts at addr 0.
6. INIT_EN=0: release reset -> init_done=1 in the first cycle after reset release, no INIT writes, p0 request granted in that same cycle.
